// File: rtl/bcd_display_scheduler.sv
// -----------------------------------------------------------------------------
// bcd_display_scheduler
//
// Purpose:
//   Two 7-bit switch fields (A = SW[17:11], B = SW[10:4]) share one serial
//   double-dabble binary-to-BCD converter. A refresh tick starts a conversion.
//   The pointer alternates between A and B after every conversion. Each field
//   is saturated to SAT_MAX (99) before conversion. The two resulting decimal
//   digits are encoded for active-low 7-segment displays.
//
// Ports:
//   CLOCK_50   in   1   system clock, rising-edge active
//   RESET_N    in   1   asynchronous active-low reset
//   SW         in   18  raw switches: [17:11]=A, [10:4]=B, [3:0] unused
//   HEX7/HEX6  out  7   A tens / units digit, active-low {g,f,e,d,c,b,a}
//   HEX5/HEX4  out  7   B tens / units digit
//   BUSY       out  1   high while a conversion is in flight (SHIFT, STORE)
//
// Configuration:
//   `define DEBOUNCE_EN adds a per-field stability filter. A field reaches the
//   converter only after it has been unchanged for DEB_CNT cycles. When the
//   macro is undefined, the converter reads the synchronised field directly.
// -----------------------------------------------------------------------------
module bcd_display_scheduler #(
    parameter int IN_W        = 7,
    parameter int SAT_MAX     = 99,
    parameter int REFRESH_DIV = 50000,
    parameter int DEB_CNT     = 16
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [17:0] SW,
    output logic [6:0]  HEX7,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX4,
    output logic        BUSY
);

    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int STEP_W = $clog2(IN_W + 1);
    localparam int F2_W   = 2 * IN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STORE = 2'd2
    } state_t;

    // Active-low segment encoder. A nibble above 9 blanks the digit.
    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // SW[3:0] is not connected to any logic.
    logic unused_sw_s;
    assign unused_sw_s = ^SW[3:0];

    logic [F2_W-1:0]   sync1_r;
    logic [F2_W-1:0]   sync2_r;
    logic [IN_W-1:0]   field_a_s;
    logic [IN_W-1:0]   field_b_s;
    logic [CNT_W-1:0]  tick_cnt_r;
    logic              tick_s;
    state_t            state_r;
    state_t            next_state_s;
    logic              load_s;
    logic              shift_s;
    logic              store_s;
    logic              busy_next_s;
    logic              ptr_r;
    logic [IN_W-1:0]   bin_r;
    logic [3:0]        tens_r;
    logic [3:0]        units_r;
    logic [STEP_W-1:0] step_r;
    logic [3:0]        tens_adj_s;
    logic [3:0]        units_adj_s;
    logic [IN_W-1:0]   sel_field_s;
    logic [IN_W-1:0]   sat_field_s;
    logic [6:0]        hex7_r;
    logic [6:0]        hex6_r;
    logic [6:0]        hex5_r;
    logic [6:0]        hex4_r;
    logic              busy_r;

    // Two-flop synchroniser for both switch fields.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_r <= {F2_W{1'b0}};
            sync2_r <= {F2_W{1'b0}};
        end else begin
            sync1_r <= SW[17 -: F2_W];
            sync2_r <= sync1_r;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DEB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

    logic [IN_W-1:0]  cand_r [2];
    logic [IN_W-1:0]  filt_r [2];
    logic [DEB_W-1:0] deb_cnt_r [2];
    logic [IN_W-1:0]  raw_s [2];

    assign raw_s[0] = sync2_r[F2_W-1 -: IN_W];
    assign raw_s[1] = sync2_r[IN_W-1:0];

    // Stability filter: any change restarts the count. The filtered value
    // follows the candidate only after DEB_CNT unchanged cycles.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 2; i++) begin
                cand_r[i]    <= {IN_W{1'b0}};
                filt_r[i]    <= {IN_W{1'b0}};
                deb_cnt_r[i] <= {DEB_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw_s[i] != cand_r[i]) begin
                    cand_r[i]    <= raw_s[i];
                    deb_cnt_r[i] <= {DEB_W{1'b0}};
                end else if (deb_cnt_r[i] != DEB_W'(DEB_CNT - 1)) begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DEB_W'(1);
                end else begin
                    filt_r[i] <= cand_r[i];
                end
            end
        end
    end

    assign field_a_s = filt_r[0];
    assign field_b_s = filt_r[1];
`else
    assign field_a_s = sync2_r[F2_W-1 -: IN_W];
    assign field_b_s = sync2_r[IN_W-1:0];
`endif

    // Free-running refresh divider. The tick is the last count of each period.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            tick_cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {CNT_W{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + CNT_W'(1);
        end
    end

    assign tick_s = (tick_cnt_r == CNT_W'(REFRESH_DIV - 1));

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic. A tick outside IDLE is dropped.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (tick_s) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (step_r == STEP_W'(IN_W - 1)) begin
                    next_state_s = STORE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            STORE:   next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM output decode: datapath strobes and next value of BUSY.
    always_comb begin
        load_s      = 1'b0;
        shift_s     = 1'b0;
        store_s     = 1'b0;
        busy_next_s = (next_state_s != IDLE);
        case (state_r)
            IDLE:    load_s  = tick_s;
            SHIFT:   shift_s = 1'b1;
            STORE:   store_s = 1'b1;
            default: begin
                load_s  = 1'b0;
                shift_s = 1'b0;
                store_s = 1'b0;
            end
        endcase
    end

    // Field selection, saturation, and double-dabble add-3 correction.
    always_comb begin
        sel_field_s = field_a_s;
        sat_field_s = field_a_s;
        if (ptr_r) begin
            sel_field_s = field_b_s;
        end else begin
            sel_field_s = field_a_s;
        end
        if (sel_field_s > IN_W'(SAT_MAX)) begin
            sat_field_s = IN_W'(SAT_MAX);
        end else begin
            sat_field_s = sel_field_s;
        end
        if (tens_r >= 4'd5) begin
            tens_adj_s = tens_r + 4'd3;
        end else begin
            tens_adj_s = tens_r;
        end
        if (units_r >= 4'd5) begin
            units_adj_s = units_r + 4'd3;
        end else begin
            units_adj_s = units_r;
        end
    end

    // Converter datapath, pointer, and registered display and BUSY outputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            bin_r   <= {IN_W{1'b0}};
            tens_r  <= 4'd0;
            units_r <= 4'd0;
            step_r  <= {STEP_W{1'b0}};
            ptr_r   <= 1'b0;
            hex7_r  <= 7'h40;
            hex6_r  <= 7'h40;
            hex5_r  <= 7'h40;
            hex4_r  <= 7'h40;
            busy_r  <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            if (load_s) begin
                bin_r   <= sat_field_s;
                tens_r  <= 4'd0;
                units_r <= 4'd0;
                step_r  <= {STEP_W{1'b0}};
            end else if (shift_s) begin
                // Shift {tens, units, bin} left by one after the correction.
                tens_r  <= {tens_adj_s[2:0], units_adj_s[3]};
                units_r <= {units_adj_s[2:0], bin_r[IN_W-1]};
                bin_r   <= {bin_r[IN_W-2:0], 1'b0};
                step_r  <= step_r + STEP_W'(1);
            end
            if (store_s) begin
                if (ptr_r) begin
                    hex5_r <= seg7_encode(tens_r);
                    hex4_r <= seg7_encode(units_r);
                end else begin
                    hex7_r <= seg7_encode(tens_r);
                    hex6_r <= seg7_encode(units_r);
                end
                ptr_r <= ~ptr_r;
            end
        end
    end

    assign HEX7 = hex7_r;
    assign HEX6 = hex6_r;
    assign HEX5 = hex5_r;
    assign HEX4 = hex4_r;
    assign BUSY = busy_r;

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_scheduler
//
// Directed, table-driven bench for bcd_display_scheduler. It uses
// REFRESH_DIV=16 and DEB_CNT=4. Conversions follow the DUT's BUSY pulse. The
// first conversion after reset serves A, and later conversions alternate
// between A and B.
// -----------------------------------------------------------------------------
module tb_bcd_display_scheduler;

    localparam int REFRESH_DIV = 16;
    localparam int DEB_CNT     = 4;

    logic        clk;
    logic        rst_n;
    logic [17:0] sw;
    logic [6:0]  hex7;
    logic [6:0]  hex6;
    logic [6:0]  hex5;
    logic [6:0]  hex4;
    logic        busy;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        logic [6:0] a;
        logic [6:0] b;
        logic [6:0] h7;
        logic [6:0] h6;
        logic [6:0] h5;
        logic [6:0] h4;
    } vec_t;

    vec_t vecs [8];

    bcd_display_scheduler #(
        .IN_W        (7),
        .SAT_MAX     (99),
        .REFRESH_DIV (REFRESH_DIV),
        .DEB_CNT     (DEB_CNT)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .SW       (sw),
        .HEX7     (hex7),
        .HEX6     (hex6),
        .HEX5     (hex5),
        .HEX4     (hex4),
        .BUSY     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_sw(input logic [6:0] a, input logic [6:0] b);
        sw = {a, b, 4'b0000};
    endtask

    // Returns at the first negedge where BUSY is high, or after the bound.
    task automatic wait_busy_rise(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("busy_rise_timeout", 32'(seen), 32'd1);
    endtask

    // Called while BUSY is high. Counts high negedges and returns at the first low one.
    task automatic wait_busy_fall(output int len);
        len = 1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (!busy) break;
            len++;
        end
    endtask

    task automatic run_conv(output int len);
        bit seen;
        wait_busy_rise(seen);
        len = 0;
        if (seen) wait_busy_fall(len);
    endtask

    initial begin
        int len;
        int cnt;
        bit seen;

        pass_cnt  = 0;
        total_cnt = 0;

        vecs[0] = '{7'd42,  7'd7,   7'h19, 7'h24, 7'h40, 7'h78};
        vecs[1] = '{7'd127, 7'd100, 7'h10, 7'h10, 7'h10, 7'h10};
        vecs[2] = '{7'd99,  7'd0,   7'h10, 7'h10, 7'h40, 7'h40};
        vecs[3] = '{7'd0,   7'd99,  7'h40, 7'h40, 7'h10, 7'h10};
        vecs[4] = '{7'd15,  7'd88,  7'h79, 7'h12, 7'h00, 7'h00};
        vecs[5] = '{7'd100, 7'd63,  7'h10, 7'h10, 7'h02, 7'h30};
        vecs[6] = '{7'd56,  7'd31,  7'h12, 7'h02, 7'h30, 7'h79};
        vecs[7] = '{7'd9,   7'd10,  7'h40, 7'h10, 7'h79, 7'h40};

        // Test 1: reset state and the first tick after release.
        rst_n = 1'b0;
        set_sw(7'd0, 7'd0);
        repeat (3) @(negedge clk);
        check("rst_hex7", 32'(hex7), 32'h40);
        check("rst_hex6", 32'(hex6), 32'h40);
        check("rst_hex5", 32'(hex5), 32'h40);
        check("rst_hex4", 32'(hex4), 32'h40);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cnt++;
            if (busy) break;
        end
        check("first_tick_cycles", 32'(cnt), 32'(REFRESH_DIV));
        wait_busy_fall(len);
        check("first_busy_len", 32'(len), 32'd8);
        run_conv(len);

        // Tests 2 and 3: table of field pairs. Each pair gets one settling
        // round and then one checked round.
        for (int v = 0; v < 8; v++) begin
            set_sw(vecs[v].a, vecs[v].b);
            run_conv(len);
            run_conv(len);
            run_conv(len);
            check("vec_busy_len_a", 32'(len), 32'd8);
            check("vec_hex7", 32'(hex7), 32'(vecs[v].h7));
            check("vec_hex6", 32'(hex6), 32'(vecs[v].h6));
            run_conv(len);
            check("vec_busy_len_b", 32'(len), 32'd8);
            check("vec_hex5", 32'(hex5), 32'(vecs[v].h5));
            check("vec_hex4", 32'(hex4), 32'(vecs[v].h4));
        end

        // Test 4: a switch change after the latch cycle does not affect the conversion in flight.
        set_sw(7'd15, 7'd0);
        run_conv(len);
        run_conv(len);
        wait_busy_rise(seen);
        @(negedge clk);
        set_sw(7'd88, 7'd0);
        if (seen) wait_busy_fall(len);
        check("inflight_hex7", 32'(hex7), 32'h79);
        check("inflight_hex6", 32'(hex6), 32'h12);
        run_conv(len);
        run_conv(len);
        check("next_slot_hex7", 32'(hex7), 32'h00);
        check("next_slot_hex6", 32'(hex6), 32'h00);
        run_conv(len);

`ifdef DEBOUNCE_EN
        // Test 6: a short glitch is filtered, and a held value is accepted.
        set_sw(7'd30, 7'd0);
        run_conv(len);
        run_conv(len);
        set_sw(7'd55, 7'd0);
        repeat (2) @(negedge clk);
        set_sw(7'd30, 7'd0);
        run_conv(len);
        check("deb_glitch_hex7", 32'(hex7), 32'h30);
        check("deb_glitch_hex6", 32'(hex6), 32'h40);
        run_conv(len);
        set_sw(7'd55, 7'd0);
        run_conv(len);
        run_conv(len);
        run_conv(len);
        check("deb_hold_hex7", 32'(hex7), 32'h12);
        check("deb_hold_hex6", 32'(hex6), 32'h12);
        run_conv(len);
`endif

        // Test 5: an asynchronous reset during SHIFT step 3 takes effect at once.
        set_sw(7'd23, 7'd61);
        wait_busy_rise(seen);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hex7", 32'(hex7), 32'h40);
        check("midrst_hex6", 32'(hex6), 32'h40);
        check("midrst_hex5", 32'(hex5), 32'h40);
        check("midrst_hex4", 32'(hex4), 32'h40);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cnt++;
            if (busy) break;
        end
        check("rerst_tick_cycles", 32'(cnt), 32'(REFRESH_DIV));
        wait_busy_fall(len);
        check("rerst_a_hex7", 32'(hex7), 32'h24);
        check("rerst_a_hex6", 32'(hex6), 32'h30);
        check("rerst_b_hold5", 32'(hex5), 32'h40);
        check("rerst_b_hold4", 32'(hex4), 32'h40);
        run_conv(len);
        check("rerst_b_hex5", 32'(hex5), 32'h02);
        check("rerst_b_hex4", 32'(hex4), 32'h79);
        check("rerst_a_keep7", 32'(hex7), 32'h24);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
